// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It handles multi-cycle data reads,
// load-use hazards and taken PCSrc flushes, and keeps saturating stall and flush counters.
module pipeline_hazard_controller #(
   parameter int MEM_READ_LATENCY = 1,
   parameter int CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       id_rs1,
   input  logic [2:0]       id_rs2,
   input  logic [1:0]       id_uses_rs,
   input  logic             ex_mem_read,
   input  logic [2:0]       ex_rd,
   input  logic             mem_read_req,
   input  logic             pcsrc,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             mem_data_valid,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   localparam bit         HAS_WAIT = (MEM_READ_LATENCY > 0);
   localparam logic [1:0] LAT      = MEM_READ_LATENCY[1:0];

   state_t           state_q, state_d;
   logic [1:0]       wcnt_q, wcnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             load_use;
   logic             flush_evt;

   assign load_use = ex_mem_read &&
                     ((id_uses_rs[0] && (id_rs1 == ex_rd)) ||
                      (id_uses_rs[1] && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wcnt_q  <= 2'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         RUN: begin
            if (mem_read_req && HAS_WAIT) begin
               state_d = MEM_WAIT;
               wcnt_d  = LAT;
            end
         end
         MEM_WAIT: begin
            if (wcnt_q > 2'd1) begin
               wcnt_d = wcnt_q - 2'd1;
            end else begin
               state_d = RUN;
               wcnt_d  = 2'd0;
            end
         end
         default: begin
            state_d = RUN;
            wcnt_d  = 2'd0;
         end
      endcase
   end

   always_comb begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      id_ex_en       = 1'b0;
      ex_mem_en      = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      mem_wb_bubble  = 1'b0;
      mem_data_valid = 1'b0;
      flush_evt      = 1'b0;
      // Everything stays quiet while reset is held, whatever the inputs say.
      if (rst_n) begin
         case (state_q)
            RUN: begin
               mem_data_valid = !HAS_WAIT && mem_read_req;
               if (mem_read_req && HAS_WAIT) begin
                  mem_wb_bubble = 1'b1;
               end else begin
                  pc_en     = 1'b1;
                  if_id_en  = 1'b1;
                  id_ex_en  = 1'b1;
                  ex_mem_en = 1'b1;
                  if (pcsrc) begin
                     if_id_flush  = 1'b1;
                     id_ex_flush  = 1'b1;
                     ex_mem_flush = 1'b1;
                     flush_evt    = 1'b1;
                  end else if (load_use) begin
                     pc_en       = 1'b0;
                     if_id_en    = 1'b0;
                     id_ex_flush = 1'b1;
                  end
               end
            end
            MEM_WAIT: begin
               if (wcnt_q > 2'd1) begin
                  mem_wb_bubble = 1'b1;
               end else begin
                  // Release cycle: the load moves to WB, but ID may still depend on EX.
                  mem_data_valid = 1'b1;
                  pc_en          = !load_use;
                  if_id_en       = !load_use;
                  id_ex_en       = 1'b1;
                  ex_mem_en      = 1'b1;
                  id_ex_flush    = load_use;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!pc_en && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + 1'b1;
      if (flush_evt && (flush_q != {CNT_W{1'b1}}))
         flush_d = flush_q + 1'b1;
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: dut_a (latency 1, 16-bit counters) and dut_b (latency 3, 4-bit counters)
// share stimulus; expectations are queued per cycle and checked on the falling edge.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] id_rs1, id_rs2, ex_rd;
   logic [1:0] id_uses_rs;
   logic       ex_mem_read, mem_read_req, pcsrc;

   logic a_pc, a_ifid, a_idex, a_exmem, a_fif, a_fidex, a_fexmem, a_bub, a_val;
   logic b_pc, b_ifid, b_idex, b_exmem, b_fif, b_fidex, b_fexmem, b_bub, b_val;
   logic [15:0] a_stall, a_flush;
   logic [3:0]  b_stall, b_flush;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.MEM_READ_LATENCY(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs(id_uses_rs),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_read_req(mem_read_req), .pcsrc(pcsrc),
      .pc_en(a_pc), .if_id_en(a_ifid), .id_ex_en(a_idex), .ex_mem_en(a_exmem),
      .if_id_flush(a_fif), .id_ex_flush(a_fidex), .ex_mem_flush(a_fexmem),
      .mem_wb_bubble(a_bub), .mem_data_valid(a_val),
      .stall_count(a_stall), .flush_count(a_flush));

   pipeline_hazard_controller #(.MEM_READ_LATENCY(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs(id_uses_rs),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_read_req(mem_read_req), .pcsrc(pcsrc),
      .pc_en(b_pc), .if_id_en(b_ifid), .id_ex_en(b_idex), .ex_mem_en(b_exmem),
      .if_id_flush(b_fif), .id_ex_flush(b_fidex), .ex_mem_flush(b_fexmem),
      .mem_wb_bubble(b_bub), .mem_data_valid(b_val),
      .stall_count(b_stall), .flush_count(b_flush));

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush, bubble, valid}
   logic [8:0] obs_a, obs_b;
   assign obs_a = {a_pc, a_ifid, a_idex, a_exmem, a_fif, a_fidex, a_fexmem, a_bub, a_val};
   assign obs_b = {b_pc, b_ifid, b_idex, b_exmem, b_fif, b_fidex, b_fexmem, b_bub, b_val};

   localparam logic [8:0] O_RST  = 9'b0000_000_0_0;
   localparam logic [8:0] O_RUN  = 9'b1111_000_0_0;
   localparam logic [8:0] O_STL  = 9'b0000_000_1_0;
   localparam logic [8:0] O_BR   = 9'b1111_111_0_0;
   localparam logic [8:0] O_LU   = 9'b0011_010_0_0;
   localparam logic [8:0] O_REL  = 9'b1111_000_0_1;
   localparam logic [8:0] O_RLU  = 9'b0011_010_0_1;

   typedef struct {
      string      name;
      int         dut;
      logic [8:0] outs;
      int         stall;
      int         flush;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic push(input string n, input int d, input logic [8:0] o, input int s, input int f);
      exp_t e;
      e.name = n; e.dut = d; e.outs = o; e.stall = s; e.flush = f;
      sb.push_back(e);
   endtask

   task automatic push2(input string n, input logic [8:0] oa, input int sa,
                        input logic [8:0] ob, input int sbv, input int f);
      push(n, 0, oa, sa, f);
      push(n, 1, ob, sbv, f);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 3'd0; id_rs2 = 3'd0; id_uses_rs = 2'b00; ex_rd = 3'd0;
      ex_mem_read = 1'b0; mem_read_req = 1'b0; pcsrc = 1'b0;
   endtask

   task automatic set_lu(input logic [1:0] uses, input logic [2:0] rs1, input logic [2:0] rs2);
      ex_mem_read = 1'b1; ex_rd = 3'd3; id_uses_rs = uses; id_rs1 = rs1; id_rs2 = rs2;
   endtask

   // Monitor: the controller presents a response every cycle, so check on each falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [8:0] o;
         int s, f;
         e = sb.pop_front();
         o = (e.dut == 0) ? obs_a : obs_b;
         s = (e.dut == 0) ? int'(a_stall) : int'(b_stall);
         f = (e.dut == 0) ? int'(a_flush) : int'(b_flush);
         n_tests++;
         if (o !== e.outs) begin
            n_fail++;
            $display("FAIL %s dut%0d outputs: got %b expected %b", e.name, e.dut, o, e.outs);
         end
         n_tests++;
         if (s != e.stall) begin
            n_fail++;
            $display("FAIL %s dut%0d stall_count: got %0d expected %0d", e.name, e.dut, s, e.stall);
         end
         n_tests++;
         if (f != e.flush) begin
            n_fail++;
            $display("FAIL %s dut%0d flush_count: got %0d expected %0d", e.name, e.dut, f, e.flush);
         end
         $display("[TB] %s dut%0d outs=%b stall=%0d flush=%0d", e.name, e.dut, o, s, f);
      end
   end

   initial begin
      idle();
      rst_n = 1'b0; pcsrc = 1'b1; mem_read_req = 1'b1;
      step();
      push2("T1_reset", O_RST, 0, O_RST, 0, 0);
      step();

      rst_n = 1'b1; idle();
      push2("run0", O_RUN, 0, O_RUN, 0, 0);
      step();

      // One load; dut_a waits 1 cycle, dut_b waits 3.
      mem_read_req = 1'b1;
      push2("load_c0", O_STL, 0, O_STL, 0, 0);
      step();
      pcsrc = 1'b1;  // ignored while either controller sits in MEM_WAIT
      push2("load_c1", O_REL, 1, O_STL, 1, 0);
      step();
      idle();
      push2("load_c2", O_RUN, 1, O_STL, 2, 0);
      step();
      push2("load_c3", O_RUN, 1, O_REL, 3, 0);
      step();
      push2("load_c4", O_RUN, 1, O_RUN, 3, 0);
      step();

      set_lu(2'b10, 3'd0, 3'd3);
      push2("lu_rs2", O_LU, 1, O_LU, 3, 0);
      step();
      set_lu(2'b01, 3'd0, 3'd3);
      push2("lu_rs2_unused", O_RUN, 2, O_RUN, 4, 0);
      step();
      set_lu(2'b01, 3'd3, 3'd0);
      push2("lu_rs1", O_LU, 2, O_LU, 4, 0);
      step();
      set_lu(2'b01, 3'd3, 3'd0); ex_mem_read = 1'b0;
      push2("lu_noload", O_RUN, 3, O_RUN, 5, 0);
      step();

      set_lu(2'b10, 3'd0, 3'd3); pcsrc = 1'b1;
      push2("br_over_lu", O_BR, 3, O_BR, 5, 0);
      step();
      idle();
      push2("br_after", O_RUN, 3, O_RUN, 5, 1);
      step();

      // Load followed by a load-use hazard on dut_a's release cycle.
      mem_read_req = 1'b1;
      push2("rel_lu_c0", O_STL, 3, O_STL, 5, 1);
      step();
      idle(); set_lu(2'b10, 3'd0, 3'd3);
      push2("rel_lu_c1", O_RLU, 4, O_STL, 6, 1);
      step();
      idle();
      push2("rel_lu_c2", O_RUN, 5, O_STL, 7, 1);
      step();
      push2("rel_lu_c3", O_RUN, 5, O_REL, 8, 1);
      step();

      // Hold a load-use stall for 20 cycles; dut_b's 4-bit counter must stop at 15.
      set_lu(2'b10, 3'd0, 3'd3);
      for (int i = 0; i < 20; i++) begin
         push2("sat", O_LU, 5 + i, O_LU, (8 + i > 15) ? 15 : 8 + i, 1);
         step();
      end
      idle();
      push2("sat_end", O_RUN, 25, O_RUN, 15, 1);
      step();

      // Reset while dut_b is in MEM_WAIT.
      mem_read_req = 1'b1;
      push2("rstw_c0", O_STL, 25, O_STL, 15, 1);
      step();
      idle();
      push2("rstw_c1", O_REL, 26, O_STL, 15, 1);
      step();
      rst_n = 1'b0;
      push2("rstw_rst", O_RST, 0, O_RST, 0, 0);
      step();
      rst_n = 1'b1;
      push2("rstw_run0", O_RUN, 0, O_RUN, 0, 0);
      step();
      push2("rstw_run1", O_RUN, 0, O_RUN, 0, 0);
      step();

      step();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
